data_mem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the processor core (load/store path) and a DMA/loader port used for program/data preload and debug readback.
- At most one memory access per cycle.
- Core has default priority; a bounded-burst fairness counter guarantees DMA progress.
- Sits between the core's ALU-result/store-data path and the DataMemory instance.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_rsp.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the data-memory arbiter:
//     - owner_e        : which requester received the most recent grant
//     - DEF_ADDR_W/DATA_W : default bus widths of core, DMA and memory
//     - burstCntWidth  : width of the consecutive-grant counter for a given
//                        maximum burst length
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Last granted requester; OWN_NONE after an idle cycle or reset.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Bits needed to hold 0..maxBurst; never narrower than one bit.
    function automatic int burstCntWidth(input int maxBurst);
        int w;
        w = $clog2(maxBurst + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_rsp.sv
// -----------------------------------------------------------------------------
// mem_arb_rsp
//   Read-response register for one requester. When the requester is granted a
//   read, the combinational memory data is captured at the clock edge and
//   rvalid pulses for exactly the following cycle. rdata holds its last value
//   while rvalid is low. Asynchronous reset clears both, which also cancels a
//   response that was due on the next edge.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   capture  in   granted read this cycle
//   memRdata in   memory read data (combinational from the address)
//   rvalid   out  read data valid, one cycle after the grant
//   rdata    out  registered read data
// -----------------------------------------------------------------------------
module mem_arb_rsp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [DATA_W-1:0] memRdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // Capture read data and raise rvalid for the cycle after a read grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= {DATA_W{1'b0}};
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= memRdata;
            end else begin
                rdata <= rdata;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the single-port data memory between the processor core (load/store)
//   and a DMA/loader port. One access per cycle. The core wins ties by default;
//   a saturating burst counter forces a hand-over after MAX_BURST consecutive
//   grants to one side while the other is waiting, and lets an active DMA run
//   finish its MAX_BURST before the core takes over again.
//
//   Grants and the memory drive are combinational from the requests and the
//   registered (lastOwner, burstCnt) state; the access happens in the grant
//   cycle. Read data returns one cycle later through mem_arb_rsp.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   core_req/write/addr/wdata  core request (level, held until granted)
//   core_gnt                   core access performed this cycle
//   core_rvalid/rdata          registered core load response
//   dma_req/write/addr/wdata   DMA request (level, held until granted)
//   dma_gnt                    DMA access performed this cycle
//   dma_rvalid/rdata           registered DMA read response
//   mem_addr/wdata/read/write  memory command for the granted requester
//   mem_rdata                  memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = burstCntWidth(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1'b1);

    // Requests are masked while reset is asserted so that every combinational
    // output (grants and memory command) reads 0 during reset.
    logic reqCore;
    logic reqDma;
    assign reqCore = core_req & reset;
    assign reqDma  = dma_req  & reset;

    owner_e           lastOwner;
    owner_e           nextOwner;
    owner_e           grantOwner;
    logic [CNT_W-1:0] burstCnt;
    logic [CNT_W-1:0] nextCnt;
    logic             grantCore;
    logic             grantDma;

    // Arbitration: single requester always wins; under contention the core
    // wins unless its run is exhausted or a DMA run has not yet reached
    // MAX_BURST.
    always_comb begin
        grantCore = 1'b0;
        grantDma  = 1'b0;
        case ({reqCore, reqDma})
            2'b10: begin
                grantCore = 1'b1;
            end
            2'b01: begin
                grantDma = 1'b1;
            end
            2'b11: begin
                if ((lastOwner == OWN_CORE) && (burstCnt == MAX_CNT)) begin
                    grantDma = 1'b1;
                end else if ((lastOwner == OWN_DMA) && (burstCnt < MAX_CNT)) begin
                    grantDma = 1'b1;
                end else begin
                    grantCore = 1'b1;
                end
            end
            default: begin
                grantCore = 1'b0;
                grantDma  = 1'b0;
            end
        endcase
    end

    // Next-state: an idle cycle clears the history; a repeated owner extends
    // its run (saturating); a new owner starts a run of one.
    always_comb begin
        nextOwner  = OWN_NONE;
        nextCnt    = {CNT_W{1'b0}};
        grantOwner = OWN_NONE;
        if (grantCore) begin
            grantOwner = OWN_CORE;
        end else if (grantDma) begin
            grantOwner = OWN_DMA;
        end else begin
            grantOwner = OWN_NONE;
        end

        if (grantOwner == OWN_NONE) begin
            nextOwner = OWN_NONE;
            nextCnt   = {CNT_W{1'b0}};
        end else if (grantOwner == lastOwner) begin
            nextOwner = lastOwner;
            if (burstCnt == MAX_CNT) begin
                nextCnt = MAX_CNT;
            end else begin
                nextCnt = burstCnt + ONE_CNT;
            end
        end else begin
            nextOwner = grantOwner;
            nextCnt   = ONE_CNT;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastOwner <= OWN_NONE;
            burstCnt  <= {CNT_W{1'b0}};
        end else begin
            lastOwner <= nextOwner;
            burstCnt  <= nextCnt;
        end
    end

    // Memory command mux: the granted requester drives the bus; exactly one
    // strobe is high per granted cycle and the bus is all-zero when idle.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (grantCore) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_read  = ~core_write;
            mem_write = core_write;
        end else if (grantDma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = ~dma_write;
            mem_write = dma_write;
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign core_gnt = grantCore;
    assign dma_gnt  = grantDma;

    logic captureCore;
    logic captureDma;
    assign captureCore = grantCore & ~core_write;
    assign captureDma  = grantDma  & ~dma_write;

    mem_arb_rsp #(
        .DATA_W (DATA_W)
    ) u_core_rsp (
        .clk      (clk),
        .reset    (reset),
        .capture  (captureCore),
        .memRdata (mem_rdata),
        .rvalid   (core_rvalid),
        .rdata    (core_rdata)
    );

    mem_arb_rsp #(
        .DATA_W (DATA_W)
    ) u_dma_rsp (
        .clk      (clk),
        .reset    (reset),
        .capture  (captureDma),
        .memRdata (mem_rdata),
        .rvalid   (dma_rvalid),
        .rdata    (dma_rdata)
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Bench for data_mem_arbiter: a MAX_BURST=4 instance exercised with a vector
//   table, hand-written reset sequence and randomized traffic against a
//   behavioural model, plus a MAX_BURST=1 instance for strict alternation.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int MB_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A (MAX_BURST = 4)
    logic        coreReq, coreWrite, coreGnt, coreRvalid;
    logic [31:0] coreAddr, coreWdata, coreRdata;
    logic        dmaReq, dmaWrite, dmaGnt, dmaRvalid;
    logic [31:0] dmaAddr, dmaWdata, dmaRdata;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memRead, memWrite;

    // Instance B (MAX_BURST = 1)
    logic        bCoreReq, bCoreGnt, bCoreRvalid;
    logic [31:0] bCoreRdata;
    logic        bDmaReq, bDmaGnt, bDmaRvalid;
    logic [31:0] bDmaRdata;
    logic [31:0] bMemAddr, bMemWdata, bMemRdata;
    logic        bMemRead, bMemWrite;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB_A)) dutA (
        .clk(clk), .reset(reset),
        .core_req(coreReq), .core_write(coreWrite), .core_addr(coreAddr),
        .core_wdata(coreWdata), .core_gnt(coreGnt), .core_rvalid(coreRvalid),
        .core_rdata(coreRdata),
        .dma_req(dmaReq), .dma_write(dmaWrite), .dma_addr(dmaAddr),
        .dma_wdata(dmaWdata), .dma_gnt(dmaGnt), .dma_rvalid(dmaRvalid),
        .dma_rdata(dmaRdata),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_read(memRead),
        .mem_write(memWrite), .mem_rdata(memRdata)
    );

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dutB (
        .clk(clk), .reset(reset),
        .core_req(bCoreReq), .core_write(1'b0), .core_addr(32'h0000_0010),
        .core_wdata(32'h0000_0000), .core_gnt(bCoreGnt), .core_rvalid(bCoreRvalid),
        .core_rdata(bCoreRdata),
        .dma_req(bDmaReq), .dma_write(1'b0), .dma_addr(32'h0000_0020),
        .dma_wdata(32'h0000_0000), .dma_gnt(bDmaGnt), .dma_rvalid(bDmaRvalid),
        .dma_rdata(bDmaRdata),
        .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_read(bMemRead),
        .mem_write(bMemWrite), .mem_rdata(bMemRdata)
    );

    assign bMemRdata = ~bMemAddr;

    // Memory for instance A: word (i) holds 0x90 + 4*i after reset.
    logic [31:0] memArr [0:255];
    assign memRdata = memArr[memAddr[9:2]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) memArr[i] <= 32'h90 + 32'(i) * 32'd4;
        end else if (memWrite) begin
            memArr[memAddr[9:2]] <= memWdata;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic driveA(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                          input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        coreReq = cr; coreWrite = cw; coreAddr = ca; coreWdata = cd;
        dmaReq  = dr; dmaWrite  = dw; dmaAddr  = da; dmaWdata  = dd;
    endtask

    // Expected memory command for a given grant outcome.
    task automatic chkMem(input string nm, input logic gC, input logic gD,
                          input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                          input logic dw, input logic [31:0] da, input logic [31:0] dd);
        logic        eR, eW;
        logic [31:0] eA, eD;
        eR = 1'b0; eW = 1'b0; eA = 32'h0; eD = 32'h0;
        if (gC) begin
            eR = !cw; eW = cw; eA = ca; eD = cd;
        end else if (gD) begin
            eR = !dw; eW = dw; eA = da; eD = dd;
        end
        chk({nm, " mem_read"},  32'(memRead),  32'(eR));
        chk({nm, " mem_write"}, 32'(memWrite), 32'(eW));
        chk({nm, " mem_addr"},  memAddr,  eA);
        chk({nm, " mem_wdata"}, memWdata, eD);
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        eCg, eDg, eCv, eDv;
        logic [31:0] eRd;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                                input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic eCg, input logic eDg, input logic eCv, input logic eDv,
                                input logic [31:0] eRd);
        row_t r;
        r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
        r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.eCg = eCg; r.eDg = eDg; r.eCv = eCv; r.eDv = eDv; r.eRd = eRd;
        return r;
    endfunction

    // Behavioural reference state for the random phase.
    int          mOwner;   // 0 none, 1 core, 2 dma
    int          mRun;     // length of the current grant streak
    logic [31:0] refMem [0:255];
    logic        expCv, expDv;
    logic [31:0] expCd, expDd;

    initial begin
        logic        pC, pD, gC, gD, cW, dW;
        logic [31:0] cA, cD, dA, dD;
        int          cWait, dWait;
        logic        prevCore;

        // ---------------- reset state ----------------
        reset = 1'b0;
        driveA(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h77);
        bCoreReq = 1'b0; bDmaReq = 1'b0;
        #3;
        chk("rst core_gnt", 32'(coreGnt), 32'd0);
        chk("rst dma_gnt", 32'(dmaGnt), 32'd0);
        chk("rst core_rvalid", 32'(coreRvalid), 32'd0);
        chk("rst dma_rvalid", 32'(dmaRvalid), 32'd0);
        chk("rst core_rdata", coreRdata, 32'd0);
        chk("rst dma_rdata", dmaRdata, 32'd0);
        chkMem("rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        driveA(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- MAX_BURST = 1 alternation ----------------
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bCoreReq = 1'b1; bDmaReq = 1'b1;
            #1;
            chk($sformatf("b%0d core_gnt", i), 32'(bCoreGnt), 32'((i % 2) == 0));
            chk($sformatf("b%0d dma_gnt", i), 32'(bDmaGnt), 32'((i % 2) == 1));
            chk($sformatf("b%0d mem_read", i), 32'(bMemRead), 32'd1);
            chk($sformatf("b%0d mem_write", i), 32'(bMemWrite), 32'd0);
            chk($sformatf("b%0d mem_wdata", i), bMemWdata, 32'd0);
            if (i > 0) begin
                chk($sformatf("b%0d core_rvalid", i), 32'(bCoreRvalid), 32'(((i - 1) % 2) == 0));
                chk($sformatf("b%0d dma_rvalid", i), 32'(bDmaRvalid), 32'(((i - 1) % 2) == 1));
                if (((i - 1) % 2) == 0) chk($sformatf("b%0d core_rdata", i), bCoreRdata, ~32'h10);
                else                    chk($sformatf("b%0d dma_rdata", i), bDmaRdata, ~32'h20);
            end
        end
        @(negedge clk);
        bCoreReq = 1'b0; bDmaReq = 1'b0;

        // ---------------- vector table ----------------
        // tie from idle: core writes 0x20=0x55, DMA reads 0x20
        rows.push_back(mk(1'b1, 1'b1, 32'h20, 32'h55, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        // continuous contention from idle: core x4, DMA x4, core x4
        prevCore = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic thisCore;
            thisCore = (k < 4) || (k >= 8);
            rows.push_back(mk(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0,
                              thisCore, !thisCore,
                              (k > 0) && prevCore, (k > 0) && !prevCore,
                              (k == 0) ? 32'h0 : (prevCore ? 32'hC0 : 32'hD0)));
            prevCore = thisCore;
        end
        // core-only loads
        rows.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0));
        rows.push_back(mk(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0));
        rows.push_back(mk(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA4));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA8));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        // DMA owns, core arrives in cycle 2
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h100, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h104, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b1, 32'h108, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b1, 32'h10C, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b1, 32'h110, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h110, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA8));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h108, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        rows.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h33));

        foreach (rows[i]) begin
            string nm;
            nm = $sformatf("row%0d", i);
            @(negedge clk);
            driveA(rows[i].cr, rows[i].cw, rows[i].ca, rows[i].cd,
                   rows[i].dr, rows[i].dw, rows[i].da, rows[i].dd);
            #1;
            chk({nm, " core_gnt"}, 32'(coreGnt), 32'(rows[i].eCg));
            chk({nm, " dma_gnt"},  32'(dmaGnt),  32'(rows[i].eDg));
            chkMem(nm, rows[i].eCg, rows[i].eDg, rows[i].cw, rows[i].ca, rows[i].cd,
                   rows[i].dw, rows[i].da, rows[i].dd);
            chk({nm, " core_rvalid"}, 32'(coreRvalid), 32'(rows[i].eCv));
            chk({nm, " dma_rvalid"},  32'(dmaRvalid),  32'(rows[i].eDv));
            if (rows[i].eCv) chk({nm, " core_rdata"}, coreRdata, rows[i].eRd);
            if (rows[i].eDv) chk({nm, " dma_rdata"},  dmaRdata,  rows[i].eRd);
        end

        // ---------------- reset mid-read ----------------
        @(negedge clk);
        driveA(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rmid core_gnt", 32'(coreGnt), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rmid core_gnt low", 32'(coreGnt), 32'd0);
        chkMem("rmid", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("rmid core_rvalid", 32'(coreRvalid), 32'd0);
        chk("rmid core_rdata", coreRdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        driveA(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rmid after core_rvalid", 32'(coreRvalid), 32'd0);
        @(negedge clk);
        driveA(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0);
        #1;
        chk("rmid tie core_gnt", 32'(coreGnt), 32'd1);
        chk("rmid tie dma_gnt", 32'(dmaGnt), 32'd0);

        // ---------------- randomized traffic vs. model ----------------
        @(negedge clk);
        reset = 1'b0;
        driveA(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        mOwner = 0; mRun = 0;
        for (int i = 0; i < 256; i++) refMem[i] = 32'h90 + 32'(i) * 32'd4;
        expCv = 1'b0; expDv = 1'b0; expCd = 32'h0; expDd = 32'h0;
        pC = 1'b0; pD = 1'b0; cWait = 0; dWait = 0;
        cW = 1'b0; dW = 1'b0; cA = 32'h0; dA = 32'h0; cD = 32'h0; dD = 32'h0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            string nm;
            nm = $sformatf("rnd%0d", cyc);
            @(negedge clk);
            if (pC && $urandom_range(0, 15) == 0) begin pC = 1'b0; cWait = 0; end
            if (pD && $urandom_range(0, 15) == 0) begin pD = 1'b0; dWait = 0; end
            if (!pC && $urandom_range(0, 3) != 0) begin
                pC = 1'b1; cW = 1'($urandom_range(0, 1));
                cA = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; cD = $urandom;
            end
            if (!pD && $urandom_range(0, 3) != 0) begin
                pD = 1'b1; dW = 1'($urandom_range(0, 1));
                dA = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; dD = $urandom;
            end
            driveA(pC, cW, cA, cD, pD, dW, dA, dD);
            #1;
            // Core's turn by default; DMA keeps the bus until its streak hits
            // MAX_BURST, and takes it once the core's streak hits MAX_BURST.
            gC = 1'b0; gD = 1'b0;
            if (pC && pD) begin
                if ((mOwner == 1 && mRun >= MB_A) || (mOwner == 2 && mRun < MB_A)) gD = 1'b1;
                else gC = 1'b1;
            end else begin
                gC = pC; gD = pD;
            end
            chk({nm, " core_gnt"}, 32'(coreGnt), 32'(gC));
            chk({nm, " dma_gnt"},  32'(dmaGnt),  32'(gD));
            chkMem(nm, gC, gD, cW, cA, cD, dW, dA, dD);
            chk({nm, " core_rvalid"}, 32'(coreRvalid), 32'(expCv));
            chk({nm, " dma_rvalid"},  32'(dmaRvalid),  32'(expDv));
            chk({nm, " core_rdata"}, coreRdata, expCd);
            chk({nm, " dma_rdata"},  dmaRdata,  expDd);

            expCv = gC && !cW;
            expDv = gD && !dW;
            if (expCv) expCd = refMem[cA[9:2]];
            if (expDv) expDd = refMem[dA[9:2]];
            if (gC && cW) refMem[cA[9:2]] = cD;
            if (gD && dW) refMem[dA[9:2]] = dD;

            if (gC) begin
                chk({nm, " core wait bound"}, 32'(cWait <= MB_A), 32'd1);
                pC = 1'b0; cWait = 0;
            end else if (pC) cWait++;
            if (gD) begin
                chk({nm, " dma wait bound"}, 32'(dWait <= MB_A), 32'd1);
                pD = 1'b0; dWait = 0;
            end else if (pD) dWait++;

            if (!gC && !gD) begin
                mOwner = 0; mRun = 0;
            end else if ((gC && mOwner == 1) || (gD && mOwner == 2)) begin
                mRun++;
            end else begin
                mOwner = gC ? 1 : 2; mRun = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
